// File: rtl/tx_packet_fifo.sv
// -----------------------------------------------------------------------------
// tx_packet_fifo
//
// Store-and-forward AXI-Stream packet buffer placed in front of tx_mac. A frame
// is only made visible on the output once its tlast word has been stored, so
// the output stream never has a tvalid gap inside a frame. Frames that cannot
// fit even in an otherwise empty buffer are discarded and flagged.
//
// Ports
//   clk               single clock
//   reset_n           asynchronous active-low reset
//   s00_axis_*        user transmit stream in (tdata, tkeep, tvalid, tready, tlast)
//   m00_axis_*        stream out to tx_mac   (tdata, tkeep, tvalid, tready, tlast)
//   frame_count       committed frames whose tlast has not yet left the output
//   frame_dropped     one-cycle pulse when an oversize frame has been discarded
// -----------------------------------------------------------------------------
module tx_packet_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_NBYTES = DATA_WIDTH / 8,
  parameter int DEPTH       = 512
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    s00_axis_tdata,
  input  logic [DATA_NBYTES-1:0]   s00_axis_tkeep,
  input  logic                     s00_axis_tvalid,
  output logic                     s00_axis_tready,
  input  logic                     s00_axis_tlast,
  output logic [DATA_WIDTH-1:0]    m00_axis_tdata,
  output logic [DATA_NBYTES-1:0]   m00_axis_tkeep,
  output logic                     m00_axis_tvalid,
  input  logic                     m00_axis_tready,
  output logic                     m00_axis_tlast,
  output logic [$clog2(DEPTH):0]   frame_count,
  output logic                     frame_dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 1 + DATA_NBYTES + DATA_WIDTH;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_t;

  // Packet storage, entry = {tlast, tkeep, tdata}
  logic [EW-1:0] mem [DEPTH];

  // Pointers wrap modulo 2*DEPTH so that full and empty are distinguishable.
  // rd_ptr advances on the output handshake, so words sitting in the output
  // skid buffer still count as occupied; fetch_ptr is the RAM read address.
  logic [PW-1:0] wr_cur;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fetch_ptr;
  logic [PW-1:0] used;
  logic [PW-1:0] committed_unread;
  logic          full;

  // Holds s00_axis_tready low until the first clock after reset release
  logic          run_q;

  wr_state_t     state_q;
  wr_state_t     state_d;
  logic          wr_en;
  logic          commit;
  logic          drop_enter;
  logic          drop_done;

  // Read pipeline and two-entry output skid buffer
  logic          rd_vld_p0;
  logic          rd_vld_p1;
  logic [EW-1:0] rd_data_p1;
  logic [1:0]    sk_cnt;
  logic [EW-1:0] sk_ent0;
  logic [EW-1:0] sk_ent1;
  logic [1:0]    occ;
  logic          m_pop;
  logic          m_last_hs;

  assign used             = wr_cur - rd_ptr;
  assign committed_unread = wr_ptr - rd_ptr;
  assign full             = (used == PW'(DEPTH));

  // ---------------------------------------------------------------------------
  // Write side: accept / drop state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    s00_axis_tready = 1'b0;
    wr_en           = 1'b0;
    commit          = 1'b0;
    drop_enter      = 1'b0;
    drop_done       = 1'b0;
    if (run_q) begin
      case (state_q)
        ACCEPT: begin
          s00_axis_tready = !full;
          if (full && (committed_unread == '0)) begin
            // The whole buffer holds only the current frame and it still has
            // not ended: it can never be stored, so rewind and swallow the rest.
            drop_enter = 1'b1;
            state_d    = DROP;
          end else if (s00_axis_tvalid && !full) begin
            wr_en  = 1'b1;
            commit = s00_axis_tlast;
          end
        end
        DROP: begin
          s00_axis_tready = 1'b1;
          if (s00_axis_tvalid && s00_axis_tlast) begin
            drop_done = 1'b1;
            state_d   = ACCEPT;
          end
        end
        default: state_d = ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ACCEPT;
      run_q         <= 1'b0;
      wr_cur        <= '0;
      wr_ptr        <= '0;
      frame_dropped <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      state_q       <= state_d;
      frame_dropped <= drop_done;
      if (drop_enter) begin
        wr_cur <= wr_ptr;
      end else if (wr_en) begin
        wr_cur <= wr_cur + PW'(1);
      end
      if (commit) begin
        wr_ptr <= wr_cur + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_cur[AW-1:0]] <= {s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: RAM read issue. Only committed words (below wr_ptr) are fetched,
  // and at most two words are ever held between RAM output and skid buffer.
  // A fetch is allowed at occupancy 2 only when the head is leaving this cycle.
  // ---------------------------------------------------------------------------
  assign occ       = sk_cnt + {1'b0, rd_vld_p1};
  assign m_pop     = m00_axis_tvalid && m00_axis_tready;
  assign m_last_hs = m_pop && m00_axis_tlast;
  assign rd_vld_p0 = (fetch_ptr != wr_ptr) &&
                     ((occ < 2'd2) || ((occ == 2'd2) && m_pop));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_ptr   <= '0;
      rd_ptr      <= '0;
      rd_vld_p1   <= 1'b0;
      sk_cnt      <= 2'd0;
      frame_count <= '0;
    end else begin
      rd_vld_p1 <= rd_vld_p0;
      if (rd_vld_p0) begin
        fetch_ptr <= fetch_ptr + PW'(1);
      end
      if (m_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({rd_vld_p1, m_pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: sk_cnt <= sk_cnt;
      endcase
      // A commit and an output tlast in the same cycle cancel out
      case ({commit, m_last_hs})
        2'b10:   frame_count <= frame_count + PW'(1);
        2'b01:   frame_count <= frame_count - PW'(1);
        default: frame_count <= frame_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld_p0) begin
      rd_data_p1 <= mem[fetch_ptr[AW-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: RAM output into the skid buffer. sk_ent0 is the presented word;
  // it only changes on a pop or when the buffer is empty, which keeps the
  // output stable under backpressure.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sk_ent0 <= '0;
    end else if (m_pop) begin
      if (sk_cnt == 2'd2) begin
        sk_ent0 <= sk_ent1;
      end else if (rd_vld_p1) begin
        sk_ent0 <= rd_data_p1;
      end
    end else if (rd_vld_p1 && (sk_cnt == 2'd0)) begin
      sk_ent0 <= rd_data_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld_p1 && (((sk_cnt == 2'd1) && !m_pop) || ((sk_cnt == 2'd2) && m_pop))) begin
      sk_ent1 <= rd_data_p1;
    end
  end

  assign m00_axis_tvalid = (sk_cnt != 2'd0);
  assign {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata} = sk_ent0;

endmodule
